// File: rtl/ex_mem_reg_pkg.sv
// Shared EX/MEM definitions: default widths, NZCV bit positions and the beat payload layout.
// Flag fields exist in the payload only when EX_MEM_FLAGS_EN is defined.
package ex_mem_reg_pkg;

    localparam int EX_MEM_DATA_W     = 32;
    localparam int EX_MEM_REG_ADDR_W = 4;

    localparam int NZCV_W = 4;
    localparam int NZCV_N = 3;
    localparam int NZCV_Z = 2;
    localparam int NZCV_C = 1;
    localparam int NZCV_V = 0;

    typedef struct packed {
        logic                         reg_write_enable;
        logic                         mem_write_enable;
        logic                         mem_to_reg_select;
`ifdef EX_MEM_FLAGS_EN
        logic                         status_bits;
        logic [NZCV_W-1:0]            flags;
`endif
        logic [EX_MEM_DATA_W-1:0]     alu_result;
        logic [EX_MEM_DATA_W-1:0]     store_data;
        logic [EX_MEM_REG_ADDR_W-1:0] rd;
    } ex_mem_payload_t;

    function automatic logic [NZCV_W-1:0] nzcv_pack(
        input logic n,
        input logic z,
        input logic c,
        input logic v
    );
        logic [NZCV_W-1:0] f;
        f         = '0;
        f[NZCV_N] = n;
        f[NZCV_Z] = z;
        f[NZCV_C] = c;
        f[NZCV_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/ex_mem_reg_skid_buffer.sv
// Two-entry skid buffer: main entry drives the output, skid entry absorbs one beat while main is stalled.
// Latency 1 cycle into an empty main; in_ready is a flop, so no combinational path from out_ready to in_ready.
module ex_mem_reg_skid_buffer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_dat,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_dat
);

    logic         main_vld_q, main_vld_d;
    logic         skid_vld_q, skid_vld_d;
    logic [W-1:0] main_dat_q, main_dat_d;
    logic [W-1:0] skid_dat_q, skid_dat_d;
    logic         rdy_q;
    logic         accept;
    logic         drain;

    assign accept = in_valid && rdy_q;
    assign drain  = main_vld_q && out_ready;

    always_comb begin
        main_vld_d = main_vld_q;
        skid_vld_d = skid_vld_q;
        main_dat_d = main_dat_q;
        skid_dat_d = skid_dat_q;
        if (flush) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (skid_vld_q) begin
            // rdy_q is low while skid holds a beat, so nothing new can arrive here
            if (drain) begin
                main_dat_d = skid_dat_q;
                skid_vld_d = 1'b0;
            end
        end else if (!main_vld_q || drain) begin
            main_vld_d = accept;
            if (accept) begin
                main_dat_d = in_dat;
            end
        end else if (accept) begin
            skid_vld_d = 1'b1;
            skid_dat_d = in_dat;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            main_dat_q <= '0;
            skid_dat_q <= '0;
            rdy_q      <= 1'b0;
        end else begin
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
            main_dat_q <= main_dat_d;
            skid_dat_q <= skid_dat_d;
            rdy_q      <= !skid_vld_d;
        end
    end

    assign in_ready  = rdy_q;
    assign out_valid = main_vld_q;
    assign out_dat   = main_dat_q;

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: packs execute results into a skid buffer, qualifies write enables, keeps committed NZCV.
// The flag register is built only when EX_MEM_FLAGS_EN is defined; otherwise flags_q is constant zero.
module ex_mem_reg
    import ex_mem_reg_pkg::*;
#(
    parameter int DATA_W     = EX_MEM_DATA_W,
    parameter int REG_ADDR_W = EX_MEM_REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  reg_write_enable_in,
    input  logic                  mem_write_enable_in,
    input  logic                  mem_to_reg_select_in,
    input  logic                  status_bits_in,
    input  logic [DATA_W-1:0]     alu_result_in,
    input  logic [DATA_W-1:0]     store_data_in,
    input  logic [REG_ADDR_W-1:0] rd_in,
    input  logic [NZCV_W-1:0]     flags_in,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  reg_write_enable_out,
    output logic                  mem_write_enable_out,
    output logic                  mem_to_reg_select_out,
    output logic [DATA_W-1:0]     alu_result_out,
    output logic [DATA_W-1:0]     store_data_out,
    output logic [REG_ADDR_W-1:0] rd_out,
    output logic [NZCV_W-1:0]     flags_q
);

    // Payload field widths come from the package, so DATA_W/REG_ADDR_W track its defaults.
    ex_mem_payload_t in_pl;
    ex_mem_payload_t out_pl;

    always_comb begin
        in_pl                   = '0;
        in_pl.reg_write_enable  = reg_write_enable_in;
        in_pl.mem_write_enable  = mem_write_enable_in;
        in_pl.mem_to_reg_select = mem_to_reg_select_in;
`ifdef EX_MEM_FLAGS_EN
        in_pl.status_bits       = status_bits_in;
        in_pl.flags             = flags_in;
`endif
        in_pl.alu_result        = alu_result_in;
        in_pl.store_data        = store_data_in;
        in_pl.rd                = rd_in;
    end

    ex_mem_reg_skid_buffer #(
        .W($bits(ex_mem_payload_t))
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_dat   (in_pl),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_dat  (out_pl)
    );

    assign reg_write_enable_out  = out_valid && out_pl.reg_write_enable;
    assign mem_write_enable_out  = out_valid && out_pl.mem_write_enable;
    assign mem_to_reg_select_out = out_pl.mem_to_reg_select;
    assign alu_result_out        = out_pl.alu_result;
    assign store_data_out        = out_pl.store_data;
    assign rd_out                = out_pl.rd;

`ifdef EX_MEM_FLAGS_EN
    logic [NZCV_W-1:0] nzcv_q, nzcv_d;
    logic              commit;

    // A flushed beat never transfers, so it must not commit flags either.
    assign commit = out_valid && out_ready && !flush && out_pl.status_bits;

    always_comb begin
        nzcv_d = nzcv_q;
        if (commit) begin
            nzcv_d = out_pl.flags;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nzcv_q <= '0;
        end else begin
            nzcv_q <= nzcv_d;
        end
    end

    assign flags_q = nzcv_q;
`else
    logic unused_flag_inputs;
    assign unused_flag_inputs = ^{status_bits_in, flags_in};
    assign flags_q            = '0;
`endif

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed bench for ex_mem_reg: accepted beats are queued, a negedge monitor pops and compares transfers.
module tb_ex_mem_reg;

    typedef struct packed {
        logic        rwe;
        logic        mwe;
        logic        m2r;
        logic [31:0] alu;
        logic [31:0] st;
        logic [3:0]  rd;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        rwe_i, mwe_i, m2r_i, sb_i;
    logic [31:0] alu_i, st_i;
    logic [3:0]  rd_i, fl_i;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic        rwe_o, mwe_o, m2r_o;
    logic [31:0] alu_o, st_o;
    logic [3:0]  rd_o;
    logic [3:0]  flags_q;

    beat_t exp_q[$];
    beat_t cur;
    int    n_checks = 0;
    int    n_fail   = 0;

    ex_mem_reg dut (
        .clk                  (clk),
        .reset                (reset),
        .in_valid             (in_valid),
        .in_ready             (in_ready),
        .reg_write_enable_in  (rwe_i),
        .mem_write_enable_in  (mwe_i),
        .mem_to_reg_select_in (m2r_i),
        .status_bits_in       (sb_i),
        .alu_result_in        (alu_i),
        .store_data_in        (st_i),
        .rd_in                (rd_i),
        .flags_in             (fl_i),
        .flush                (flush),
        .out_valid            (out_valid),
        .out_ready            (out_ready),
        .reg_write_enable_out (rwe_o),
        .mem_write_enable_out (mwe_o),
        .mem_to_reg_select_out(m2r_o),
        .alu_result_out       (alu_o),
        .store_data_out       (st_o),
        .rd_out               (rd_o),
        .flags_q              (flags_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic beat_t mk(input logic [31:0] alu, input logic [31:0] st, input logic [3:0] rd,
                                 input logic rwe, input logic mwe, input logic m2r);
        beat_t b;
        b.rwe = rwe;
        b.mwe = mwe;
        b.m2r = m2r;
        b.alu = alu;
        b.st  = st;
        b.rd  = rd;
        return b;
    endfunction

    task automatic offer(input beat_t b, input logic sb, input logic [3:0] fl);
        cur      = b;
        in_valid = 1'b1;
        rwe_i    = b.rwe;
        mwe_i    = b.mwe;
        m2r_i    = b.m2r;
        alu_i    = b.alu;
        st_i     = b.st;
        rd_i     = b.rd;
        sb_i     = sb;
        fl_i     = fl;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        sb_i     = 1'b0;
    endtask

    // One clock: record an accept (or a flush) before the edge, return 1 ns after it.
    task automatic step();
        @(negedge clk);
        if (flush) exp_q.delete();
        else if (in_valid && in_ready) exp_q.push_back(cur);
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        beat_t a, e;
        forever begin
            @(negedge clk);
            if (!reset && out_valid && out_ready && !flush) begin
                a = mk(alu_o, st_o, rd_o, rwe_o, mwe_o, m2r_o);
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL scoreboard: unexpected beat alu=%h rd=%0d", a.alu, a.rd);
                end else begin
                    e = exp_q.pop_front();
                    if (a !== e) begin
                        n_fail++;
                        $display("FAIL scoreboard: got alu=%h st=%h rd=%0d we=%b%b%b, expected alu=%h st=%h rd=%0d we=%b%b%b",
                                 a.alu, a.st, a.rd, a.rwe, a.mwe, a.m2r, e.alu, e.st, e.rd, e.rwe, e.mwe, e.m2r);
                    end
                end
            end
            if (!out_valid) check("qual_we_idle", 32'({rwe_o, mwe_o}), 32'd0);
        end
    end

    initial begin : stim
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        rwe_i = 1'b0; mwe_i = 1'b0; m2r_i = 1'b0; sb_i = 1'b0;
        alu_i = '0; st_i = '0; rd_i = '0; fl_i = '0;
        cur = '0;
        #3;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_alu", alu_o, 32'd0);
        check("rst_rd", 32'(rd_o), 32'd0);
        check("rst_flags", 32'(flags_q), 32'd0);
        #9 reset = 1'b0;
        @(posedge clk); #1;
        check("in_ready_after_reset", 32'(in_ready), 32'd1);

        // single beat, 1-cycle latency
        out_ready = 1'b1;
        offer(mk(32'h0000_0010, 32'hDEAD_0001, 4'd3, 1'b1, 1'b0, 1'b0), 1'b0, 4'h0);
        step();
        idle();
        check("single_out_valid", 32'(out_valid), 32'd1);
        check("single_alu", alu_o, 32'h10);
        check("single_rd", 32'(rd_o), 32'd3);
        check("single_rwe", 32'(rwe_o), 32'd1);
        step();
        check("single_drained", 32'(out_valid), 32'd0);

        // back-pressure: A in main, B in skid, C refused until skid drains
        out_ready = 1'b0;
        offer(mk(32'd1, 32'h100, 4'd1, 1'b1, 1'b0, 1'b0), 1'b0, 4'h0); step();
        offer(mk(32'd2, 32'h200, 4'd2, 1'b0, 1'b1, 1'b0), 1'b0, 4'h0); step();
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        offer(mk(32'd3, 32'h300, 4'd4, 1'b1, 1'b0, 1'b1), 1'b0, 4'h0); step();
        check("bp_main_held", alu_o, 32'd1);
        check("bp_still_full", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        step();
        check("bp_ready_back", 32'(in_ready), 32'd1);
        check("bp_b_in_main", alu_o, 32'd2);
        step();
        idle();
        check("bp_c_in_main", alu_o, 32'd3);
        step();
        check("bp_empty", 32'(out_valid), 32'd0);

        // streaming: accept and transfer on the same edge
        for (int i = 0; i < 4; i++) begin
            offer(mk(32'h1000 + 32'(i), 32'h2000 + 32'(i), 4'(i + 8), 1'b1, 1'b1, 1'b0), 1'b0, 4'h0);
            step();
            check("stream_in_ready", 32'(in_ready), 32'd1);
            check("stream_out_valid", 32'(out_valid), 32'd1);
        end
        idle(); step();

        // flush with both entries full and a beat on the input
        out_ready = 1'b0;
        offer(mk(32'hAA, 32'h1, 4'd5, 1'b1, 1'b0, 1'b0), 1'b0, 4'h0); step();
        offer(mk(32'hBB, 32'h2, 4'd6, 1'b1, 1'b0, 1'b0), 1'b0, 4'h0); step();
        offer(mk(32'hCC, 32'h3, 4'd7, 1'b1, 1'b0, 1'b0), 1'b0, 4'h0);
        flush = 1'b1; step(); flush = 1'b0; idle();
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        // flush with an acceptable beat: it must be discarded
        offer(mk(32'hDD, 32'h4, 4'd8, 1'b1, 1'b0, 1'b0), 1'b0, 4'h0); step();
        offer(mk(32'hEE, 32'h5, 4'd9, 1'b1, 1'b0, 1'b0), 1'b0, 4'h0);
        flush = 1'b1; step(); flush = 1'b0; idle();
        check("flush2_out_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        step(); step();
        check("flush_nothing_appears", 32'(out_valid), 32'd0);

        // qualification
        mwe_i = 1'b1; rwe_i = 1'b1; #1;
        check("qual_unaccepted_mwe", 32'(mwe_o), 32'd0);
        offer(mk(32'h44, 32'h4444, 4'd10, 1'b1, 1'b1, 1'b1), 1'b0, 4'h0); step();
        idle();
        check("qual_live_mwe", 32'(mwe_o), 32'd1);
        step();
        check("qual_drained_mwe", 32'(mwe_o), 32'd0);
        check("qual_drained_rwe", 32'(rwe_o), 32'd0);

        // asynchronous reset with both entries full
        out_ready = 1'b0;
        offer(mk(32'h55, 32'h5555, 4'd5, 1'b1, 1'b0, 1'b1), 1'b0, 4'h0); step();
        offer(mk(32'h66, 32'h6666, 4'd6, 1'b0, 1'b1, 1'b0), 1'b0, 4'h0); step();
        idle();
        #2 reset = 1'b1;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd0);
        check("arst_we", 32'({rwe_o, mwe_o, m2r_o}), 32'd0);
        check("arst_alu", alu_o, 32'd0);
        check("arst_st", st_o, 32'd0);
        check("arst_rd", 32'(rd_o), 32'd0);
        check("arst_flags", 32'(flags_q), 32'd0);
        exp_q.delete();
        #2 reset = 1'b0;
        @(posedge clk); #1;
        check("arst_in_ready_back", 32'(in_ready), 32'd1);
        check("arst_stays_empty", 32'(out_valid), 32'd0);

        // flags: status=1 commits 0110, status=0 beat leaves it alone
        out_ready = 1'b1;
        offer(mk(32'h77, 32'h0, 4'd1, 1'b1, 1'b0, 1'b0), 1'b1, 4'b0110); step();
        idle();
        check("flags_before_xfer", 32'(flags_q), 32'd0);
        step();
`ifdef EX_MEM_FLAGS_EN
        check("flags_committed", 32'(flags_q), 32'b0110);
`else
        check("flags_tied_zero", 32'(flags_q), 32'd0);
`endif
        offer(mk(32'h88, 32'h0, 4'd2, 1'b1, 1'b0, 1'b0), 1'b0, 4'b1001); step();
        idle(); step(); step();
`ifdef EX_MEM_FLAGS_EN
        check("flags_hold", 32'(flags_q), 32'b0110);
`else
        check("flags_still_zero", 32'(flags_q), 32'd0);
`endif

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_mem_reg.md
# ex_mem_reg

EX/MEM pipeline boundary for the ARM pipeline, directly downstream of the ID/EX control register and the ALU. Captures each executed instruction's control bits, ALU result, store data, destination register and ALU flags, and presents them to the memory stage. Uses a two-entry skid buffer with valid/ready handshakes so that a memory-stage stall does not need a combinational ready path back into execute. Also supports a synchronous flush.

## Interface
Parameters:
- DATA_W, 32, width of ALU result and store data
- REG_ADDR_W, 4, destination register index width (R0-R15)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  execute stage offers a beat
- in_ready  out  1  block can accept a beat; registered, depends only on internal state
- reg_write_enable_in  in  1  from ID/EX
- mem_write_enable_in  in  1  from ID/EX
- mem_to_reg_select_in  in  1  from ID/EX
- status_bits_in  in  1  instruction sets flags
- alu_result_in  in  DATA_W  ALU output
- store_data_in  in  DATA_W  register value to store
- rd_in  in  REG_ADDR_W  destination register
- flags_in  in  4  ALU NZCV, with N at bit 3
- flush  in  1  synchronous kill of all held beats
- out_valid  out  1  memory-stage beat is present
- out_ready  in  1  memory stage consumes the beat
- reg_write_enable_out, mem_write_enable_out  out  1 each  qualified with out_valid
- mem_to_reg_select_out  out  1
- alu_result_out, store_data_out  out  DATA_W
- rd_out  out  REG_ADDR_W
- flags_q  out  4  committed NZCV (see Configuration)

## Operation
- Storage: main entry drives all outputs directly; skid entry holds at most one overflow beat.
- Accept happens when in_valid && in_ready. Transfer out happens when out_valid && out_ready.
- in_ready = !skid_valid.
- Accept, main entry empty or being drained this cycle: the beat loads into main.
- Accept, main entry holding and stalled: the beat loads into skid.
- Transfer out with skid_valid: skid moves to main and skid_valid clears.
- No beat is ever dropped or duplicated. Order is strictly preserved.
- reg_write_enable_out and mem_write_enable_out are forced to 0 whenever out_valid = 0.
- Payload outputs hold their last value when out_valid = 0. Consumers must not rely on them.
- flush: both valids clear on the next edge. A beat accepted in the same cycle is discarded. flush has priority over accept and over transfer.
- Reset, asynchronous and possible mid-operation: out_valid, skid_valid and every output go to 0, including flags_q = 4'b0000. in_ready returns to 1 after reset deasserts.

## Timing
- Latency is 1 cycle from accept to out_valid when main is empty.
- Throughput is 1 beat per cycle with out_ready held high.
- in_ready deasserts the cycle after the skid entry fills. It reasserts the cycle after a transfer drains the skid.
- Simultaneous accept and transfer with main full and skid empty: the new beat goes into main and skid stays empty.
- Full condition (main and skid both valid): in_ready = 0. in_valid is ignored.

## Configuration
- EX_MEM_FLAGS_EN defined:
  - Contains a 4-bit NZCV register.
  - Loaded from the main entry's flags on each transfer out whose status_bits is 1.
  - Otherwise holds. flush does not alter it. Reset clears it to 0.
- EX_MEM_FLAGS_EN undefined:
  - No flag register is built. flags_q is tied to 4'b0000.
  - status_bits_in and flags_in are unused. Their storage is removed from both entries.

## Structure
- Shared pipeline package holds:
  - DATA_W and REG_ADDR_W defaults
  - an NZCV bit-index constant set (N=3, Z=2, C=1, V=0)
  - a packed ex_mem_payload_t struct covering control bits, result, store data, rd and flags
- One sub-module is natural: skid_buffer, parameterised on payload width. ex_mem_reg packs and unpacks the struct and adds output qualification and the flag register.

## Test plan
- Single beat: in_valid=1 with alu_result_in=32'h0000_0010, rd_in=4'd3, reg_write_enable_in=1 and out_ready=1 -> next cycle out_valid=1, alu_result_out=32'h10, rd_out=3, reg_write_enable_out=1.
- Back-pressure: out_ready=0 while beats A=1, B=2 and C=3 are offered -> A is held in main and B in skid, in_ready=0 on the third cycle, C is not accepted. Raising out_ready then yields A, B, C in order with no gaps after C is re-offered.
- Flush: main and skid full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the in-flight beat never appears.
- Qualification: with out_valid=0 while mem_write_enable_in=1 is held un-accepted -> mem_write_enable_out=0.
- Async reset mid-stall: reset is pulsed between edges with both entries full -> all outputs 0 immediately and flags_q=0.
- Flags (EX_MEM_FLAGS_EN defined): transfer a beat with status_bits=1 and flags=4'b0110, then one with status_bits=0 and flags=4'b1001 -> flags_q=4'b0110 and it remains there.
